// File: rtl/seq_signed_divider.sv
// seq_signed_divider: iterative restoring signed divider.
// Divides a 2*DW-bit signed dividend by a DW-bit signed divisor. Magnitudes are
// divided one bit per cycle, and the signs are applied in a final SIGN cycle.
// Latency is fixed: start accepted at edge k produces done after edge k+2*DW+1.
// Optional macro SEQ_SIGNED_DIVIDER_ERR_EN adds an err output for divide-by-zero
// and for the -2^(2DW-1)/-1 overflow case. With the macro, a zero divisor also
// takes an early exit.
module seq_signed_divider #(
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2*DW-1:0] dividend,
  input  logic [DW-1:0]   divisor,
  output logic            busy,
  output logic            done,
  output logic [2*DW-1:0] quotient,
  output logic [DW-1:0]   remainder
`ifdef SEQ_SIGNED_DIVIDER_ERR_EN
  ,
  output logic            err
`endif
);

  localparam int QW = 2 * DW;
  localparam int CW = $clog2(QW);

  typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt;
  logic            sign_q, sign_r;
  logic [QW-1:0]   dvd_mag;
  logic [DW-1:0]   dvs_mag;
  logic [DW-1:0]   part_rem;

  logic [QW-1:0]   dividend_abs;
  logic [DW-1:0]   divisor_abs;
  logic [DW:0]     rem_shift;
  logic            rem_ge;
  logic [DW-1:0]   rem_step;

`ifdef SEQ_SIGNED_DIVIDER_ERR_EN
  logic            div_zero, ovf_in;
  logic            zero_q, ovf_q;
  assign div_zero = (divisor == '0);
  assign ovf_in   = (dividend == {1'b1, {(QW-1){1'b0}}}) && (divisor == '1);
`endif

  assign busy = (state != IDLE);

  // Input magnitudes and one restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    dividend_abs = dividend[QW-1] ? (~dividend + 1'b1) : dividend;
    divisor_abs  = divisor[DW-1] ? (~divisor + 1'b1) : divisor;
    rem_shift    = {part_rem, dvd_mag[QW-1]};
    rem_ge       = (rem_shift >= {1'b0, dvs_mag});
    rem_step     = rem_ge ? DW'(rem_shift - {1'b0, dvs_mag}) : rem_shift[DW-1:0];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: IDLE -> CALC for 2*DW steps -> SIGN -> IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
`ifdef SEQ_SIGNED_DIVIDER_ERR_EN
          state_next = div_zero ? SIGN : CALC;
`else
          state_next = CALC;
`endif
        end
      end
      CALC:    if (cnt == CW'(QW - 1)) state_next = SIGN;
      SIGN:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture operands on accept, iterate in CALC, and publish signed results in SIGN.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      dvd_mag   <= '0;
      dvs_mag   <= '0;
      part_rem  <= '0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
`ifdef SEQ_SIGNED_DIVIDER_ERR_EN
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
      err       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sign_q   <= dividend[QW-1] ^ divisor[DW-1];
            sign_r   <= dividend[QW-1];
            dvd_mag  <= dividend_abs;
            dvs_mag  <= divisor_abs;
            part_rem <= '0;
            cnt      <= '0;
`ifdef SEQ_SIGNED_DIVIDER_ERR_EN
            zero_q   <= div_zero;
            ovf_q    <= ovf_in;
`endif
          end
        end
        CALC: begin
          part_rem <= rem_step;
          dvd_mag  <= {dvd_mag[QW-2:0], rem_ge};
          cnt      <= cnt + 1'b1;
        end
        SIGN: begin
          done      <= 1'b1;
          quotient  <= sign_q ? (~dvd_mag + 1'b1) : dvd_mag;
          remainder <= sign_r ? (~part_rem + 1'b1) : part_rem;
`ifdef SEQ_SIGNED_DIVIDER_ERR_EN
          err       <= zero_q | ovf_q;
          if (zero_q) begin
            quotient  <= '0;
            remainder <= '0;
          end
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_signed_divider.sv
// tb_seq_signed_divider: scoreboard bench for seq_signed_divider (DW=32).
// The driver pushes the expected result and done edge for each accepted operation.
// The monitor pops one expectation and compares it whenever done is high.
module tb_seq_signed_divider;

  localparam int DW  = 32;
  localparam int LAT = 2 * DW + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [63:0]   dividend = '0;
  logic [31:0]   divisor = '0;
  logic          busy, done;
  logic [63:0]   quotient;
  logic [31:0]   remainder;
`ifdef SEQ_SIGNED_DIVIDER_ERR_EN
  logic          err;
`endif

  typedef struct {
    logic [63:0] q;
    logic [31:0] r;
    logic        e;
    int          done_at;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_done = 0;
  int   exp_done = 0;

  seq_signed_divider #(.DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder)
`ifdef SEQ_SIGNED_DIVIDER_ERR_EN
    ,
    .err       (err)
`endif
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Edge counter, so latencies can be stated as edge numbers.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h, expected %h (edge %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: on every done pulse, pop the oldest expectation and compare it.
  always @(negedge clk) begin
    if (done) begin
      n_done++;
      if (sb.size() == 0) begin
        check_output("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t x;
        x = sb.pop_front();
        check_output("quotient", quotient, x.q);
        check_output("remainder", {32'd0, remainder}, {32'd0, x.r});
        check_output("done_edge", 64'(cyc), 64'(x.done_at));
        check_output("busy_in_done", {63'd0, busy}, 64'd0);
`ifdef SEQ_SIGNED_DIVIDER_ERR_EN
        check_output("err", {63'd0, err}, {63'd0, x.e});
`endif
      end
    end
  end

  // Drive one operation, called at a negedge, so it is accepted at edge cyc+1.
  task automatic apply_stimulus(input logic [63:0] dvd, input logic [31:0] dvs,
                                input logic [63:0] eq, input logic [31:0] er,
                                input logic ee, input int lat);
    exp_t x;
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
    x.q = eq; x.r = er; x.e = ee; x.done_at = cyc + 1 + lat;
    sb.push_back(x);
    exp_done++;
    @(negedge clk);
    start    = 1'b0;
    dividend = 64'hDEAD_BEEF_0BAD_F00D;
    divisor  = 32'h1234_5678;
  endtask

  // Wait until the monitor has seen every expected done, with a bounded cycle budget.
  task automatic wait_done();
    int t = 0;
    while (n_done < exp_done && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (n_done < exp_done) check_output("done_timeout", 64'(n_done), 64'(exp_done));
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  initial begin
    int  k;
    bit  all_busy;
    logic [63:0] q_z;
    logic [31:0] r_z;
    logic        e_z;
    int          lat_z;

    // Reset state.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_output("reset_busy", {63'd0, busy}, 64'd0);
    check_output("reset_done", {63'd0, done}, 64'd0);
    check_output("reset_quotient", quotient, 64'd0);
    check_output("reset_remainder", {32'd0, remainder}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // 100 / 7, busy from edge k through k+64.
    apply_stimulus(64'd100, 32'd7, 64'd14, 32'd2, 1'b0, LAT);
    k = cyc;
    all_busy = busy;
    repeat (LAT - 1) begin
      @(negedge clk);
      all_busy &= busy;
    end
    check_output("busy_window", {63'd0, all_busy}, 64'd1);
    wait_done();

    // Sign matrix, one after another.
    apply_stimulus(64'hFFFF_FFFF_FFFF_FF9C, 32'd7, 64'hFFFF_FFFF_FFFF_FFF2, 32'hFFFF_FFFE, 1'b0, LAT);
    wait_done();
    apply_stimulus(64'd100, 32'hFFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF2, 32'd2, 1'b0, LAT);
    wait_done();
    apply_stimulus(64'hFFFF_FFFF_FFFF_FF9C, 32'hFFFF_FFF9, 64'd14, 32'hFFFF_FFFE, 1'b0, LAT);
    wait_done();
    apply_stimulus(64'd0, 32'd5, 64'd0, 32'd0, 1'b0, LAT);
    wait_done();

    // Round trip of a multiplier product, then the overflow wrap.
    apply_stimulus(64'hC000_0000_FFFF_FFFF, 32'h8000_0001, 64'h0000_0000_7FFF_FFFF, 32'd0, 1'b0, LAT);
    wait_done();
    apply_stimulus(64'h8000_0000_0000_0000, 32'hFFFF_FFFF, 64'h8000_0000_0000_0000, 32'd0, 1'b1, LAT);
    wait_done();

    // Divide by zero with dividend -9.
`ifdef SEQ_SIGNED_DIVIDER_ERR_EN
    q_z = 64'd0; r_z = 32'd0; e_z = 1'b1; lat_z = 1;
`else
    q_z = 64'd1; r_z = 32'hFFFF_FFF7; e_z = 1'b0; lat_z = LAT;
`endif
    apply_stimulus(64'hFFFF_FFFF_FFFF_FFF7, 32'd0, q_z, r_z, e_z, lat_z);
    wait_done();

    // Re-pulsed start while busy is ignored; start held into the done cycle is accepted.
    apply_stimulus(64'd1000, 32'd3, 64'd333, 32'd1, 1'b0, LAT);
    k = cyc;
    wait_until(k + 9);
    dividend = 64'd555; divisor = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_until(k + 39);
    dividend = 64'hFFFF_FFFF_FFFF_FFB3; divisor = 32'd11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_until(k + 64);
    begin
      exp_t x;
      dividend = 64'd1000; divisor = 32'hFFFF_FFFD; start = 1'b1;
      x.q = 64'hFFFF_FFFF_FFFF_FEB3; x.r = 32'd1; x.e = 1'b0; x.done_at = k + 66 + LAT;
      sb.push_back(x);
      exp_done++;
    end
    wait_until(k + 66);
    start = 1'b0;
    wait_done();

    // Reset at edge k+30 aborts the operation; a new start at edge k+32 completes.
    @(negedge clk);
    dividend = 64'd100; divisor = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = cyc;
    wait_until(k + 29);
    rst = 1'b1;
    @(negedge clk);
    check_output("midreset_busy", {63'd0, busy}, 64'd0);
    check_output("midreset_quotient", quotient, 64'd0);
    check_output("midreset_remainder", {32'd0, remainder}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    apply_stimulus(64'd100, 32'd7, 64'd14, 32'd2, 1'b0, LAT);
    wait_done();

    repeat (5) @(negedge clk);
    check_output("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
